step_sequencer: RTL and testbench

Command-side driver for the 4-bit step state register: accepts a request for N steps and issues N single-cycle `s` step strobes at a programmed spacing. It waits one settle cycle after the last strobe, then captures the resulting 4-bit state code `y[3:0]` and signals completion. It sits between the control logic and the state register, which consumes `s` and returns its current code on `y`.

---
 rtl/step_sequencer.sv | 134 +++++++++++++
 tb/tb_step_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - step strobe sequencer with programmable gap, settle cycle and state capture
//
// Purpose:
//   Accepts a request for N steps and issues N single-cycle step strobes to the
//   4-bit state register, spaced by GAP idle cycles. After the last strobe it
//   waits one settle cycle, captures the returned state code and pulses done.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_start        request strobe, honoured only in IDLE
//   i_steps        number of strobes to issue, latched with i_start
//   i_pause        level; holds off strobes and freezes the gap counter
//   i_y            current state code from the state register
//   o_s            step strobe, one cycle per step
//   o_busy         high from the cycle after an accepted start through SETTLE
//   o_done         one-cycle completion pulse
//   o_remaining    strobes still to issue
//   o_final_state  state code captured at the end of SETTLE
module step_sequencer #(
   parameter int GAP = 1
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_start,
   input  logic [3:0] i_steps,
   input  logic       i_pause,
   input  logic [3:0] i_y,
   output logic       o_s,
   output logic       o_busy,
   output logic       o_done,
   output logic [3:0] o_remaining,
   output logic [3:0] o_final_state
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STEP,
      ST_GAP,
      ST_SETTLE,
      ST_DONE
   } state_t;

   localparam logic [2:0] GAP_LOAD = 3'(GAP);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_remaining;
   logic [3:0] w_remaining_nxt;
   logic [2:0] r_gap_cnt;
   logic [2:0] w_gap_cnt_nxt;
   logic [3:0] r_final_state;
   logic [3:0] w_final_state_nxt;
   logic       w_s;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= ST_IDLE;
         r_remaining   <= 4'd0;
         r_gap_cnt     <= 3'd0;
         r_final_state <= 4'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_remaining   <= w_remaining_nxt;
         r_gap_cnt     <= w_gap_cnt_nxt;
         r_final_state <= w_final_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_remaining_nxt   = r_remaining;
      w_gap_cnt_nxt     = r_gap_cnt;
      w_final_state_nxt = r_final_state;
      w_s               = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               if (i_steps != 4'd0) begin
                  w_remaining_nxt = i_steps;
                  w_state_nxt     = ST_STEP;
               end else begin
                  w_state_nxt = ST_SETTLE;
               end
            end
         end
         ST_STEP: begin
            if (!i_pause) begin
               w_s = 1'b1;
               if (r_remaining != 4'd0) begin
                  w_remaining_nxt = r_remaining - 4'd1;
               end
               if (r_remaining <= 4'd1) begin
                  w_state_nxt = ST_SETTLE;
               end else if (GAP != 0) begin
                  w_gap_cnt_nxt = GAP_LOAD;
                  w_state_nxt   = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            // The counter is loaded with GAP, so the last idle cycle is the one
            // that takes it from 1 to 0; the next cycle is already a STEP.
            if (!i_pause) begin
               if (r_gap_cnt != 3'd0) begin
                  w_gap_cnt_nxt = r_gap_cnt - 3'd1;
               end
               if (r_gap_cnt <= 3'd1) begin
                  w_state_nxt = ST_STEP;
               end
            end
         end
         ST_SETTLE: begin
            w_final_state_nxt = i_y;
            w_state_nxt       = ST_DONE;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // The strobe is decoded from the registered state so that an asynchronous
   // reset truncates a strobe already on the wire.
   assign o_s           = w_s;
   assign o_busy        = (r_state == ST_STEP) || (r_state == ST_GAP) || (r_state == ST_SETTLE);
   assign o_done        = (r_state == ST_DONE);
   assign o_remaining   = r_remaining;
   assign o_final_state = r_final_state;

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - self-checking bench for step_sequencer at GAP 0, 1 and 2
module tb_step_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] steps;
   logic       pause;
   logic [3:0] y;

   logic       s_o    [3];
   logic       busy_o [3];
   logic       done_o [3];
   logic [3:0] rem_o  [3];
   logic [3:0] fin_o  [3];

   logic [3:0] m_final [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   step_sequencer #(.GAP(0)) u_dut0 (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_steps(steps),
      .i_pause(pause), .i_y(y), .o_s(s_o[0]), .o_busy(busy_o[0]),
      .o_done(done_o[0]), .o_remaining(rem_o[0]), .o_final_state(fin_o[0])
   );

   step_sequencer #(.GAP(1)) u_dut1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_steps(steps),
      .i_pause(pause), .i_y(y), .o_s(s_o[1]), .o_busy(busy_o[1]),
      .o_done(done_o[1]), .o_remaining(rem_o[1]), .o_final_state(fin_o[1])
   );

   step_sequencer #(.GAP(2)) u_dut2 (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_steps(steps),
      .i_pause(pause), .i_y(y), .o_s(s_o[2]), .o_busy(busy_o[2]),
      .o_done(done_o[2]), .o_remaining(rem_o[2]), .o_final_state(fin_o[2])
   );

   // One request of n steps, checked every cycle against an event timeline.
   // Strobe k lands on the cycle where the count of un-paused cycles since
   // cycle 1 reaches k*(gap+1)+1; SETTLE follows the last strobe, done follows SETTLE.
   // pmode: 0 no pause, 1 random pause, 2 pause in cycles 2-3.
   // xstart: extra start pulses by cycle number. y is yval from cycle yfrom on.
   task automatic run_seq(input int n, input int pmode, input logic [31:0] xstart,
                          input int yfrom, input logic [3:0] yval, input string tag);
      bit         pz [256];
      bit         st [3][256];
      logic [3:0] yv [256];
      int         settle [3];
      int         donec  [3];
      int         cnt, k, last, maxc, ds;
      logic       exp_s, exp_busy, exp_done;
      logic [3:0] exp_rem, exp_fin;
      for (int c = 0; c < 256; c++) begin
         case (pmode)
            1:       pz[c] = ($urandom_range(3) == 0);
            2:       pz[c] = (c == 2) || (c == 3);
            default: pz[c] = 1'b0;
         endcase
         yv[c] = (c >= yfrom) ? yval : 4'($urandom_range(15));
      end
      maxc = 0;
      for (int g = 0; g < 3; g++) begin
         for (int c = 0; c < 256; c++) st[g][c] = 1'b0;
         cnt = 0; k = 0; last = 0;
         for (int c = 1; c < 256 && k < n; c++) begin
            if (!pz[c]) begin
               cnt++;
               if (cnt == k * (g + 1) + 1) begin
                  st[g][c] = 1'b1;
                  k++;
                  last = c;
               end
            end
         end
         settle[g] = (n == 0) ? 1 : last + 1;
         donec[g]  = settle[g] + 1;
         if (donec[g] > maxc) maxc = donec[g];
      end

      @(posedge clk); #1;
      start = 1'b1;
      steps = 4'(n);
      pause = 1'($urandom_range(1));
      y     = 4'($urandom_range(15));
      for (int c = 1; c <= maxc; c++) begin
         @(posedge clk); #1;
         start = (c < 32) ? xstart[c] : 1'b0;
         steps = 4'($urandom_range(15));
         pause = pz[c];
         y     = yv[c];
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            ds = 0;
            for (int j = 1; j < c; j++) ds += int'(st[g][j]);
            exp_s    = st[g][c];
            exp_busy = (c <= settle[g]);
            exp_done = (c == donec[g]);
            exp_rem  = 4'(n - ds);
            exp_fin  = (c >= donec[g]) ? yv[settle[g]] : m_final[g];
            checks++;
            if (s_o[g] !== exp_s) begin
               errors++;
               $display("FAIL %s gap%0d cycle %0d s: got %b expected %b", tag, g, c, s_o[g], exp_s);
            end
            checks++;
            if (busy_o[g] !== exp_busy) begin
               errors++;
               $display("FAIL %s gap%0d cycle %0d busy: got %b expected %b", tag, g, c, busy_o[g], exp_busy);
            end
            checks++;
            if (done_o[g] !== exp_done) begin
               errors++;
               $display("FAIL %s gap%0d cycle %0d done: got %b expected %b", tag, g, c, done_o[g], exp_done);
            end
            checks++;
            if (rem_o[g] !== exp_rem) begin
               errors++;
               $display("FAIL %s gap%0d cycle %0d remaining: got %0d expected %0d", tag, g, c, rem_o[g], exp_rem);
            end
            checks++;
            if (fin_o[g] !== exp_fin) begin
               errors++;
               $display("FAIL %s gap%0d cycle %0d final_state: got %b expected %b", tag, g, c, fin_o[g], exp_fin);
            end
         end
      end
      for (int g = 0; g < 3; g++) m_final[g] = yv[settle[g]];
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      start = 1'b1;
      steps = 4'd7;
      pause = 1'b0;
      y     = 4'hF;
      repeat (2) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         checks++;
         if ({s_o[g], busy_o[g], done_o[g], rem_o[g], fin_o[g]} !== 11'd0) begin
            errors++;
            $display("FAIL reset gap%0d outputs: got s=%b busy=%b done=%b rem=%0d fin=%b expected all 0",
                     g, s_o[g], busy_o[g], done_o[g], rem_o[g], fin_o[g]);
         end
         m_final[g] = 4'd0;
      end
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_gap_steps3;
      run_seq(3, 0, 32'd0, 5, 4'b1010, "steps3_y1010");
   endtask

   task automatic test_steps_zero;
      run_seq(0, 0, 32'd0, 0, 4'b0111, "steps0");
   endtask

   task automatic test_pause;
      run_seq(2, 2, 32'd0, 999, 4'd0, "pause_c2_c3");
   endtask

   task automatic test_start_ignored;
      // cycle 2: all busy; cycle 4: GAP0 in DONE, others still busy
      run_seq(2, 0, 32'h0000_0014, 999, 4'd0, "start_ignored");
   endtask

   task automatic test_reset_mid;
      logic exp_s;
      @(posedge clk); #1;
      start = 1'b1;
      steps = 4'd5;
      pause = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      #2;
      for (int g = 0; g < 3; g++) begin
         exp_s = ((4 - 1) % (g + 1)) == 0;
         checks++;
         if (s_o[g] !== exp_s || busy_o[g] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset gap%0d cycle 4: got s=%b busy=%b expected s=%b busy=1",
                     g, s_o[g], busy_o[g], exp_s);
         end
      end
      rst_n = 1'b0;
      #1;
      for (int g = 0; g < 3; g++) begin
         checks++;
         if ({s_o[g], busy_o[g], done_o[g], rem_o[g], fin_o[g]} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid gap%0d outputs: got s=%b busy=%b done=%b rem=%0d fin=%b expected all 0",
                     g, s_o[g], busy_o[g], done_o[g], rem_o[g], fin_o[g]);
         end
         m_final[g] = 4'd0;
      end
      repeat (3) begin
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            checks++;
            if (done_o[g] !== 1'b0 || busy_o[g] !== 1'b0) begin
               errors++;
               $display("FAIL reset_hold gap%0d: got done=%b busy=%b expected 0 0", g, done_o[g], busy_o[g]);
            end
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_seq(5, 0, 32'd0, 999, 4'd0, "after_reset");
   endtask

   task automatic test_random;
      for (int i = 0; i < 12; i++) begin
         run_seq(int'($urandom_range(15)), 1, 32'd0, 999, 4'd0, "random");
      end
   endtask

   task automatic test_back_to_back;
      run_seq(0, 0, 32'd0, 0, 4'b1100, "b2b_zero_a");
      run_seq(0, 1, 32'd0, 0, 4'b0011, "b2b_zero_b");
      run_seq(1, 0, 32'd0, 999, 4'd0, "b2b_one");
      run_seq(15, 0, 32'd0, 999, 4'd0, "b2b_fifteen");
      run_seq(1, 1, 32'd0, 999, 4'd0, "b2b_one_pause");
   endtask

   initial begin
      test_reset;
      test_gap_steps3;
      test_steps_zero;
      test_pause;
      test_start_ignored;
      test_reset_mid;
      test_random;
      test_back_to_back;
      @(posedge clk); #1;
      start = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
